dm_responder: RTL and testbench
===============================

# dm_responder

Data-memory responder for the pipelined MIPS core: the memory-side end of the M-stage load/store interface. It accepts a level-held request, waits a programmable number of cycles, and then commits the write or returns the read word with a one-cycle `ready` pulse. The core's stall control holds the M stage until it sees `ready`. It replaces the zero-latency DM so that stall logic can be exercised against a slow memory.

## Interface
- `ADDR_WIDTH`, default 12: word-address bits; capacity is 2^ADDR_WIDTH words (16 KiB by default).
- `LATENCY`, default 2: wait cycles between capture and response; legal range 0..15.
- `BASE`, default 32'h0000_0000: byte base of the window; must be aligned to 2^(ADDR_WIDTH+2).
- `clk` input 1: single clock; everything is updated on its rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input 1: request valid; the initiator holds it, with stable fields, until it sees `ready`.
- `we` input 1: 1 = store, 0 = load.
- `addr` input 32: byte address; bits [1:0] are ignored.
- `be` input 4: byte-lane enables for stores; bit i enables wdata[8i+7:8i].
- `wdata` input 32: store data, already lane-aligned by the core.
- `ready` output 1: one-cycle completion pulse.
- `rdata` output 32: full read word, valid only while `ready` is high.
- `err` output 1: out-of-window flag, valid only while `ready` is high.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
States: IDLE, WAIT, DONE.
- **IDLE**
  - When `req`=1, capture `we`, `addr`, `be` and `wdata` into internal registers.
  - Compute `hit` = (addr[31:ADDR_WIDTH+2] == BASE[31:ADDR_WIDTH+2]).
  - If LATENCY=0, go directly to DONE. Otherwise load `cnt`=LATENCY-1 and go to WAIT.
  - When `req`=0, stay in IDLE.
- **WAIT**
  - If `cnt`=0, go to DONE; otherwise decrement `cnt`.
  - Input fields are ignored in this state, because the captured copies are used.
- **Entering DONE** (the same edge that enters the state)
  - Store with hit: write each enabled byte lane of mem[addr[ADDR_WIDTH+1:2]]. Lanes with `be`=0 are unchanged.
  - Load with hit: register `rdata` = mem word.
  - Miss: no write, `rdata`=0, `err`=1.
  - Store with hit: `rdata` = 0.
- **DONE**
  - `ready`=1 for exactly this cycle, then go to IDLE unconditionally.
  - A `req` still high in the following IDLE cycle is treated as a new request.
- **`be`**
  - Lanes are applied as given; any combination is accepted, including 4'b0000, which makes the store a no-op that still completes.
- **Reset**
  - State goes to IDLE, `cnt` to 0, and `ready`, `rdata`, `err`, `busy` to 0.
  - Any in-flight operation is abandoned. A store whose DONE-entry edge coincides with or follows the reset edge is not committed.
  - Memory contents are not affected by reset and are zero-initialised at time 0.
- **Simultaneous events**
  - `reset` overrides every transition.
  - A `req` edge during WAIT or DONE is ignored; no queueing.

## Timing
- Capture edge: the first rising edge with `req`=1 in IDLE; call this cycle 0.
- `ready` is high in cycle LATENCY+1: with LATENCY=0, `ready` is high in cycle 1; with LATENCY=2, in cycle 3.
- `busy` is high from cycle 1 through cycle LATENCY+1 inclusive.
- A store becomes visible to a load captured at or after the edge that ends the store's DONE cycle.
- Back-to-back throughput: one access per LATENCY+2 cycles, since IDLE is occupied for at least one cycle.
- `rdata` and `err` come directly from registers, with no combinational path from inputs to outputs.
- Outside the DONE cycle, `rdata` and `err` hold 0.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `req`=1 → `ready`, `busy`, `err`=0 and `rdata`=0 throughout; first capture occurs on the first edge after `reset` falls.
- **Store then load:** LATENCY=2; store 32'hDEADBEEF to 0x10 with `be`=4'hF, then load 0x10 → each `ready` arrives in cycle 3 after its own capture; the load returns 32'hDEADBEEF with `err`=0.
- **Byte lanes:**
  - Store 32'h0000_AB00 to 0x10 with `be`=4'b0010 → a load of 0x10 returns 32'hDEADABEF.
  - A store with `be`=4'b0000 leaves the word unchanged.
- **Out of window:** BASE=0, ADDR_WIDTH=12; store to 0x0000_4000 → `ready` with `err`=1 and `rdata`=0; a load of 0x0 afterwards still returns the old data.
- **Back-to-back and LATENCY=0:** with LATENCY=0 and `req` held high across two loads → `ready` pulses in cycles 1 and 3, with `busy` low in cycle 2.
- **Reset mid-operation:** LATENCY=3; store 32'h1234_5678 to 0x20, assert `reset` in cycle 2 → no `ready` pulse; a later load of 0x20 returns the prior value.

Source files
------------

// File: rtl/dm_responder.sv
// Data-memory responder with programmable response latency for the M-stage
// load/store port. A held request is captured in IDLE, counted down in WAIT,
// and completed with a one-cycle ready pulse in DONE.
module dm_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  // Captured request fields
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic                  hit_q;

  // Live decode of the incoming request
  logic                  hit_in;
  logic [ADDR_WIDTH-1:0] idx_in;

  // Fields used by the access performed on the DONE-entry edge
  logic                  op_we;
  logic [ADDR_WIDTH-1:0] op_idx;
  logic [3:0]            op_be;
  logic [31:0]           op_wdata;
  logic                  op_hit;
  logic                  enter_done;

  logic [31:0] mem [2**ADDR_WIDTH] = '{default: '0};

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, addr[1:0]};

  assign hit_in = (addr[31:ADDR_WIDTH+2] == BASE[31:ADDR_WIDTH+2]);
  assign idx_in = addr[ADDR_WIDTH+1:2];

  // With zero latency DONE is entered on the capture edge itself, so the
  // access must use the live inputs rather than the not-yet-loaded copies.
  assign op_we    = (state == S_IDLE) ? we     : we_q;
  assign op_idx   = (state == S_IDLE) ? idx_in : idx_q;
  assign op_be    = (state == S_IDLE) ? be     : be_q;
  assign op_wdata = (state == S_IDLE) ? wdata  : wdata_q;
  assign op_hit   = (state == S_IDLE) ? hit_in : hit_q;

  assign enter_done = (state_next == S_DONE);

  assign ready = (state == S_DONE);
  assign busy  = (state != S_IDLE);

  // Next-state and wait-counter logic
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            state_next = S_DONE;
          end else begin
            state_next = S_WAIT;
            cnt_next   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = S_DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, counter and registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (enter_done) begin
        rdata <= (op_hit && !op_we) ? mem[op_idx] : '0;
        err   <= !op_hit;
      end else begin
        rdata <= '0;
        err   <= 1'b0;
      end
    end
  end

  // Request capture; the copies are only consumed after leaving IDLE
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      we_q    <= we;
      idx_q   <= idx_in;
      be_q    <= be;
      wdata_q <= wdata;
      hit_q   <= hit_in;
    end
  end

  // Byte-lane store commit, suppressed when reset lands on the same edge
  always_ff @(posedge clk) begin
    if (!reset && enter_done && op_hit && op_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (op_be[i]) begin
          mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (LATENCY 2, 0, 3) share the request
// fields and reset; each has its own req. A word-level model predicts every
// response and queues it for comparison when ready pulses.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_v;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [2:0]  ready_v, err_v, busy_v;
  logic [31:0] rdata_v [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  bit   [31:0] model [3][4096];
  int          lat [3] = '{2, 0, 3};
  logic [31:0] last_rdata;
  logic        last_err;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_WIDTH(12), .LATENCY(2), .BASE(32'h0)) u_l2 (
    .clk(clk), .reset(reset), .req(req_v[0]), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .ready(ready_v[0]), .rdata(rdata_v[0]), .err(err_v[0]), .busy(busy_v[0])
  );

  dm_responder #(.ADDR_WIDTH(12), .LATENCY(0), .BASE(32'h0)) u_l0 (
    .clk(clk), .reset(reset), .req(req_v[1]), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .ready(ready_v[1]), .rdata(rdata_v[1]), .err(err_v[1]), .busy(busy_v[1])
  );

  dm_responder #(.ADDR_WIDTH(12), .LATENCY(3), .BASE(32'h0)) u_l3 (
    .clk(clk), .reset(reset), .req(req_v[2]), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .ready(ready_v[2]), .rdata(rdata_v[2]), .err(err_v[2]), .busy(busy_v[2])
  );

  // Predict the response of one access and update the model for hit stores
  task automatic push_expect(input int inst, input logic w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] d);
    exp_t        e;
    logic [11:0] ix;
    bit          hit;
    ix      = a[13:2];
    hit     = (a[31:14] == 18'd0);
    e.err   = !hit;
    e.rdata = '0;
    if (hit && !w) e.rdata = model[inst][ix];
    if (hit && w) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) model[inst][ix][8*i +: 8] = d[8*i +: 8];
      end
    end
    sb.push_back(e);
  endtask

  // One complete access on instance inst; called just after a falling edge
  task automatic run_access(input int inst, input logic w, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] d);
    exp_t e;
    bit   got;
    got   = 0;
    we    = w;
    addr  = a;
    be    = b;
    wdata = d;
    push_expect(inst, w, a, b, d);
    req_v[inst] = 1'b1;
    for (int n = 1; n <= 30 && !got; n++) begin
      @(negedge clk);
      if (ready_v[inst] === 1'b1) begin
        got = 1;
        e   = sb.pop_front();
        last_rdata = rdata_v[inst];
        last_err   = err_v[inst];
        checks++;
        if (n != lat[inst] + 1) begin
          errors++;
          $display("FAIL ready_cycle inst=%0d addr=%h: got cycle %0d, expected %0d", inst, a, n, lat[inst] + 1);
        end
        checks++;
        if (rdata_v[inst] !== e.rdata) begin
          errors++;
          $display("FAIL rdata inst=%0d addr=%h: got %h, expected %h", inst, a, rdata_v[inst], e.rdata);
        end
        checks++;
        if (err_v[inst] !== e.err || busy_v[inst] !== 1'b1) begin
          errors++;
          $display("FAIL err_busy inst=%0d addr=%h: got err=%b busy=%b, expected err=%b busy=1", inst, a, err_v[inst], busy_v[inst], e.err);
        end
        req_v[inst] = 1'b0;
      end else begin
        checks++;
        if (busy_v[inst] !== 1'b1 || rdata_v[inst] !== 32'h0 || err_v[inst] !== 1'b0) begin
          errors++;
          $display("FAIL waiting_outputs inst=%0d cycle %0d: got busy=%b rdata=%h err=%b, expected 1/0/0", inst, n, busy_v[inst], rdata_v[inst], err_v[inst]);
        end
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout inst=%0d addr=%h: got no ready, expected ready in cycle %0d", inst, a, lat[inst] + 1);
      req_v[inst] = 1'b0;
      if (sb.size() > 0) sb.delete(0);
    end
    @(negedge clk);
    checks++;
    if (ready_v[inst] !== 1'b0 || busy_v[inst] !== 1'b0) begin
      errors++;
      $display("FAIL after_done inst=%0d: got ready=%b busy=%b, expected 0/0", inst, ready_v[inst], busy_v[inst]);
    end
  endtask

  // Outputs stay quiet under reset even with req high; first capture follows
  task automatic test_reset();
    reset = 1'b1;
    req_v = 3'b111;
    we    = 1'b0;
    addr  = 32'h10;
    be    = 4'hF;
    wdata = '0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (ready_v !== 3'b000 || busy_v !== 3'b000 || err_v !== 3'b000 ||
          rdata_v[0] !== 32'h0 || rdata_v[1] !== 32'h0 || rdata_v[2] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs: got ready=%b busy=%b err=%b rdata0=%h, expected all 0", ready_v, busy_v, err_v, rdata_v[0]);
      end
    end
    req_v = 3'b001;
    reset = 1'b0;
    run_access(0, 1'b0, 32'h10, 4'hF, 32'h0);
  endtask

  task automatic test_store_load();
    run_access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    run_access(0, 1'b0, 32'h10, 4'hF, 32'h0);
    checks++;
    if (last_rdata !== 32'hDEADBEEF || last_err !== 1'b0) begin
      errors++;
      $display("FAIL store_load: got %h err=%b, expected deadbeef err=0", last_rdata, last_err);
    end
  endtask

  task automatic test_byte_lanes();
    run_access(0, 1'b1, 32'h10, 4'b0010, 32'h0000_AB00);
    run_access(0, 1'b0, 32'h10, 4'hF, 32'h0);
    checks++;
    if (last_rdata !== 32'hDEADABEF) begin
      errors++;
      $display("FAIL lane1_store: got %h, expected deadabef", last_rdata);
    end
    run_access(0, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF);
    run_access(0, 1'b0, 32'h10, 4'hF, 32'h0);
    checks++;
    if (last_rdata !== 32'hDEADABEF) begin
      errors++;
      $display("FAIL be0_store: got %h, expected deadabef", last_rdata);
    end
  endtask

  task automatic test_out_of_window();
    run_access(0, 1'b1, 32'h0, 4'hF, 32'h1122_3344);
    run_access(0, 1'b1, 32'h0000_4000, 4'hF, 32'h5555_5555);
    checks++;
    if (last_err !== 1'b1 || last_rdata !== 32'h0) begin
      errors++;
      $display("FAIL miss_store: got err=%b rdata=%h, expected err=1 rdata=0", last_err, last_rdata);
    end
    run_access(0, 1'b0, 32'h0, 4'hF, 32'h0);
    checks++;
    if (last_rdata !== 32'h1122_3344 || last_err !== 1'b0) begin
      errors++;
      $display("FAIL miss_no_write: got %h err=%b, expected 11223344 err=0", last_rdata, last_err);
    end
  endtask

  // LATENCY=0 with req held across two loads: ready in cycles 1 and 3
  task automatic test_back_to_back();
    exp_t e;
    bit   exp_ready;
    run_access(1, 1'b1, 32'h10, 4'hF, 32'hA5A5_5A5A);
    we   = 1'b0;
    addr = 32'h10;
    be   = 4'hF;
    push_expect(1, 1'b0, 32'h10, 4'hF, 32'h0);
    push_expect(1, 1'b0, 32'h10, 4'hF, 32'h0);
    req_v[1] = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      exp_ready = (n == 1 || n == 3);
      checks++;
      if (ready_v[1] !== exp_ready || busy_v[1] !== exp_ready) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got ready=%b busy=%b, expected %b/%b", n, ready_v[1], busy_v[1], exp_ready, exp_ready);
      end
      if (ready_v[1] === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rdata_v[1] !== e.rdata || err_v[1] !== e.err) begin
          errors++;
          $display("FAIL b2b_data cycle%0d: got %h err=%b, expected %h err=%b", n, rdata_v[1], err_v[1], e.rdata, e.err);
        end
      end
      if (n == 3) req_v[1] = 1'b0;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_responses: got %0d unanswered, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Reset lands during WAIT (LATENCY=3) and on the DONE-entry edge (LATENCY=2)
  task automatic test_reset_mid_op();
    run_access(2, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D);
    run_access(0, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D);
    we    = 1'b1;
    addr  = 32'h20;
    be    = 4'hF;
    wdata = 32'h1234_5678;
    req_v = 3'b101;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    req_v = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (ready_v !== 3'b000 || busy_v !== 3'b000) begin
        errors++;
        $display("FAIL abandoned_op step %0d: got ready=%b busy=%b, expected 000/000", n, ready_v, busy_v);
      end
      @(negedge clk);
    end
    run_access(2, 1'b0, 32'h20, 4'hF, 32'h0);
    checks++;
    if (last_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL reset_wait_nocommit: got %h, expected cafef00d", last_rdata);
    end
    run_access(0, 1'b0, 32'h20, 4'hF, 32'h0);
    checks++;
    if (last_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL reset_edge_nocommit: got %h, expected cafef00d", last_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_out_of_window();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
